// File: rtl/norm_sched_if.sv
// norm_sched_if: requester, normalization-unit and response signals shared by norm_sched and its users
// master: requesters/consumer side (drives req_valid, req_type, resp_ready)
// slave: scheduler side (drives req_ready, norm_en, norm_type, norm_sel, resp_valid, resp_id)
interface norm_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int SW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [8*NUM_REQ-1:0] req_type;
  logic [NUM_REQ-1:0] req_ready;
  logic norm_en;
  logic [7:0] norm_type;
  logic [SW-1:0] norm_sel;
  logic resp_valid;
  logic [SW-1:0] resp_id;
  logic resp_ready;
  modport master (
    output req_valid, req_type, resp_ready,
    input req_ready, norm_en, norm_type, norm_sel, resp_valid, resp_id
  );
  modport slave (
    input req_valid, req_type, resp_ready,
    output req_ready, norm_en, norm_type, norm_sel, resp_valid, resp_id
  );
endinterface

// File: rtl/norm_sched.sv
// norm_sched: round-robin scheduler sharing one normalization unit among NUM_REQ requesters, one job in flight
// clk, rst_n: rising-edge clock, asynchronous active-low reset
// bus: slave side of norm_sched_if (request grant, norm unit control, response handshake)
// soft_clear: synchronous clear of job_count; busy: high outside IDLE; job_count: completed jobs (wraps)
module norm_sched #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  norm_sched_if.slave          bus,
  input  logic                 soft_clear,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] job_count
);
  localparam int SW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, last_q, last_d, gidx, cand;
  logic [7:0] type_q, type_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SW:0] sum;
  logic found, hs;
  always_comb begin
    found = 1'b0;
    gidx = '0;
    sum = '0;
    cand = '0;
    // scan from last_grant+1 upward, wrapping modulo NUM_REQ; first hit wins
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_q} + (SW+1)'(k);
      cand = sum >= (SW+1)'(NUM_REQ) ? SW'(sum - (SW+1)'(NUM_REQ)) : SW'(sum);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        gidx = cand;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    type_d = type_q;
    wcnt_d = wcnt_q;
    last_d = last_q;
    hs = 1'b0;
    unique case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        sel_d = gidx;
        type_d = bus.req_type[{gidx, 3'b000} +: 8];
      end
      ISSUE: begin
        wcnt_d = 4'(LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        state_d = wcnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP: if (bus.resp_ready) begin
        hs = 1'b1;
        last_d = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = soft_clear ? '0 : cnt_q + CNT_WIDTH'(hs);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      type_q <= '0;
      wcnt_q <= '0;
      last_q <= SW'(NUM_REQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      type_q <= type_d;
      wcnt_q <= wcnt_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  // grant is combinational in IDLE; rst_n gating keeps it quiet while reset is held
  assign bus.req_ready = (state_q == IDLE && found && rst_n) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx : '0;
  assign bus.norm_en = state_q == ISSUE;
  assign bus.norm_type = type_q;
  assign bus.norm_sel = sel_q;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_id = sel_q;
  assign busy = state_q != IDLE;
  assign job_count = cnt_q;
endmodule

// File: tb/tb_norm_sched.sv
// tb_norm_sched: directed checks of norm_sched (NUM_REQ=4, LATENCY=1, CNT_WIDTH=4)
module tb_norm_sched;
  logic clk, rst_n, soft_clear, busy;
  logic [3:0] job_count;
  logic [3:0] exp_cnt;
  int tests, fails;
  logic [7:0] typ [4] = '{8'h00, 8'hAB, 8'h01, 8'h07};
  norm_sched_if #(.NUM_REQ(4)) bus ();
  norm_sched #(.NUM_REQ(4), .LATENCY(1), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .soft_clear(soft_clear), .busy(busy), .job_count(job_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic job(input logic [3:0] mask, input int g, input bit drop, input int stall, input bit clr);
    bus.req_valid = mask;
    #1;
    chk("grant", 32'(bus.req_ready), 32'(1 << g));
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cnt", 32'(job_count), 32'(exp_cnt));
    tick();
    if (drop) bus.req_valid = mask & ~4'(1 << g);
    #1;
    chk("issue_en", 32'(bus.norm_en), 1);
    chk("issue_sel", 32'(bus.norm_sel), 32'(g));
    chk("issue_type", 32'(bus.norm_type), 32'(typ[g]));
    chk("issue_rdy", 32'(bus.req_ready), 0);
    chk("issue_busy", 32'(busy), 1);
    tick();
    chk("wait_en", 32'(bus.norm_en), 0);
    chk("wait_rv", 32'(bus.resp_valid), 0);
    chk("wait_type", 32'(bus.norm_type), 32'(typ[g]));
    tick();
    if (stall > 0) begin
      bus.resp_ready = 1'b0;
      bus.req_valid = bus.req_valid | 4'b0001;
    end
    for (int s = 0; s < stall; s++) begin
      #1;
      chk("bp_rv", 32'(bus.resp_valid), 1);
      chk("bp_id", 32'(bus.resp_id), 32'(g));
      chk("bp_sel", 32'(bus.norm_sel), 32'(g));
      chk("bp_rdy", 32'(bus.req_ready), 0);
      chk("bp_cnt", 32'(job_count), 32'(exp_cnt));
      tick();
    end
    bus.resp_ready = 1'b1;
    soft_clear = clr;
    #1;
    chk("resp_rv", 32'(bus.resp_valid), 1);
    chk("resp_id", 32'(bus.resp_id), 32'(g));
    chk("resp_en", 32'(bus.norm_en), 0);
    tick();
    soft_clear = 1'b0;
    exp_cnt = clr ? 4'd0 : exp_cnt + 4'd1;
  endtask
  initial begin
    tests = 0;
    fails = 0;
    exp_cnt = 4'd0;
    rst_n = 1'b0;
    soft_clear = 1'b0;
    bus.req_valid = 4'hF;
    bus.resp_ready = 1'b1;
    bus.req_type = {typ[3], typ[2], typ[1], typ[0]};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(bus.norm_en), 0);
    chk("rst_rv", 32'(bus.resp_valid), 0);
    chk("rst_cnt", 32'(job_count), 0);
    bus.req_valid = 4'h0;
    rst_n = 1'b1;
    #1;
    chk("idle_norv", 32'(bus.req_ready), 0);
    tick();
    chk("idle_stay", 32'(busy), 0);
    for (int j = 0; j < 5; j++) job(4'hF, j % 4, 1'b0, 0, 1'b0);
    job(4'b0001, 0, 1'b1, 0, 1'b0);
    job(4'b1100, 2, 1'b1, 0, 1'b0);
    job(4'b1000, 3, 1'b1, 5, 1'b0);
    for (int j = 0; j < 8; j++) job(4'b0010, 1, 1'b1, 0, 1'b0);
    chk("wrap", 32'(job_count), 0);
    job(4'b0001, 0, 1'b1, 0, 1'b0);
    bus.req_valid = 4'b0011;
    #1;
    chk("pre_rst_grant", 32'(bus.req_ready), 32'b0010);
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_en", 32'(bus.norm_en), 0);
    chk("mid_rst_type", 32'(bus.norm_type), 0);
    chk("mid_rst_sel", 32'(bus.norm_sel), 0);
    chk("mid_rst_rv", 32'(bus.resp_valid), 0);
    chk("mid_rst_id", 32'(bus.resp_id), 0);
    chk("mid_rst_rdy", 32'(bus.req_ready), 0);
    chk("mid_rst_cnt", 32'(job_count), 0);
    tick();
    chk("rst_hold_rv", 32'(bus.resp_valid), 0);
    rst_n = 1'b1;
    exp_cnt = 4'd0;
    job(4'b0011, 0, 1'b1, 0, 1'b0);
    job(4'b0001, 0, 1'b1, 0, 1'b1);
    chk("clr_hs", 32'(job_count), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/norm_sched.md
NORM_SCHED -- requirements
Module: norm_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one normalization unit (legal 2..8).
REQ-002 Parameter LATENCY, default 1, cycles from norm_en sampled to norm unit data_o valid (legal 1..15).
REQ-003 Parameter CNT_WIDTH, default 16, width of job_count.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: clk in 1 rising-edge clock; rst_n in 1 asynchronous active-low reset.
REQ-005 req_valid  in  NUM_REQ  per-requester job request.
REQ-006 req_type  in  8*NUM_REQ  per-requester norm type, slice i = [8i+7:8i] (0=LayerNorm, 1=RMSNorm, other=pass-through).
REQ-007 req_ready  out  NUM_REQ  one-hot grant/accept pulse.
REQ-008 norm_en  out  1  enable to normalization unit.
REQ-009 norm_type  out  8  type to normalization unit.
REQ-010 norm_sel  out  $clog2(NUM_REQ)  select for external data_i mux and result routing.
REQ-011 resp_valid  out  1  result on norm unit data_o is valid for requester resp_id.
REQ-012 resp_id  out  $clog2(NUM_REQ)  owner of current result.
REQ-013 resp_ready  in  1  consumer accepts result.
REQ-014 soft_clear  in  1  synchronous clear of job_count.
REQ-015 busy  out  1  high whenever state != IDLE.
REQ-016 job_count  out  CNT_WIDTH  completed-job counter.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one job in flight.
REQ-018 IDLE: if any req_valid, grant g = first asserted index searching round-robin from last_grant+1 (mod NUM_REQ); req_ready[g]=1 combinationally in that cycle only; latch g and req_type slice g; next state ISSUE.
REQ-019 IDLE with no req_valid: remain IDLE, req_ready all 0.
REQ-020 ISSUE: norm_en=1 for exactly one cycle, norm_type=latched type, norm_sel=g; load wait counter with LATENCY; next WAIT.
REQ-021 WAIT: counter decrements each cycle; after exactly LATENCY WAIT cycles go to RESP.
REQ-022 RESP: resp_valid=1, resp_id=g; hold until resp_valid & resp_ready; on that edge job_count+1, last_grant=g, next IDLE.
REQ-023 norm_en SHALL be 0 in all states except ISSUE; norm_type and norm_sel SHALL hold latched values from ISSUE through RESP.
REQ-024 Minimum grant-to-grant spacing SHALL be LATENCY+3 cycles (IDLE, ISSUE, LATENCY x WAIT, RESP).
REQ-025 req_valid changes outside IDLE SHALL be ignored; requesters hold req_valid and req_type until req_ready.
REQ-026 req_ready SHALL be 0 in ISSUE, WAIT, RESP.
REQ-027 job_count SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-028 soft_clear SHALL zero job_count next edge; clear and increment in same cycle yields 0.
REQ-029 Unknown type codes SHALL be forwarded unchanged; no type filtering.
REQ-030 resp_ready while resp_valid=0 SHALL have no effect.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, norm_en=0, norm_type=0, norm_sel=0, resp_valid=0, resp_id=0, req_ready=0, busy=0, job_count=0, wait counter=0, last_grant=NUM_REQ-1 (requester 0 first priority).
REQ-032 Reset mid-job SHALL abandon the job with no resp_valid; after release FSM starts in IDLE.

Verification
REQ-033 Single job: req_valid=0001, type 0, LATENCY=1, resp_ready=1 -> req_ready=0001 cycle 0, norm_en=1 cycle 1, resp_valid cycle 3 with resp_id=0, job_count=1.
REQ-034 Round-robin: req_valid=1111 held -> grants in order 0,1,2,3,0, each spaced LATENCY+3 cycles.
REQ-035 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_id, norm_sel stable, no new req_ready, job_count unchanged until handshake.
REQ-036 Type routing: requester 2 type 1, requester 3 type 8'h7 -> norm_type=1 then 7 during respective ISSUE, norm_sel=2 then 3.
REQ-037 Counter: CNT_WIDTH=4, 16 jobs -> job_count wraps to 0; soft_clear coincident with handshake -> job_count=0.
REQ-038 Reset in WAIT: rst_n low one cycle -> all outputs 0 immediately, no resp_valid, next grant goes to requester 0.
